// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, break detection,
// and a single-entry valid/ready output buffer with sticky overrun.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } state_t;

  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic par_bit);
    logic mix;
    mix = (^data) ^ par_bit;
    if (PARITY == 2) begin
      return ~mix;
    end else begin
      return mix;
    end
  endfunction

  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r;
  logic                 cnt_clr_s, shift_s, par_smp_s, done_s, brk_s, hs_s;

  // Two-flop synchroniser plus previous-sample register for start-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Frame state, bit timing counters and in-flight word assembly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      par_err_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (cnt_clr_s || state_r == ST_IDLE || state_r == ST_BRK) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (state_r == ST_START) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else if (shift_s) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (shift_s) begin
        shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
      end
      if (par_smp_s) begin
        par_err_r <= parity_err_f(shift_r, rx_sync_r);
      end else if (state_r == ST_START) begin
        par_err_r <= 1'b0;
      end
    end
  end

  // Next-state decode and per-cycle sample strobes
  always_comb begin
    state_nx_s = state_r;
    cnt_clr_s  = 1'b0;
    shift_s    = 1'b0;
    par_smp_s  = 1'b0;
    done_s     = 1'b0;
    brk_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r && rx_prev_r) begin
          state_nx_s = ST_START;
          cnt_clr_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_clr_s  = 1'b1;
          state_nx_s = rx_sync_r ? ST_IDLE : ST_DATA;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          shift_s   = 1'b1;
          cnt_clr_s = 1'b1;
          if (bit_cnt_r == BIT_LAST) begin
            state_nx_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            state_nx_s = ST_DATA;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          par_smp_s  = 1'b1;
          cnt_clr_s  = 1'b1;
          state_nx_s = ST_STOP;
        end else begin
          state_nx_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_clr_s = 1'b1;
          if (!rx_sync_r && shift_r == {DATA_BITS{1'b0}}) begin
            brk_s      = 1'b1;
            state_nx_s = ST_BRK;
          end else begin
            done_s     = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_BRK: begin
        if (rx_sync_r) begin
          cnt_clr_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BRK;
        end
      end
      default: begin
        cnt_clr_s  = 1'b1;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  assign hs_s = rx_valid & rx_ready;

  // Output buffer: a completing word replaces the buffer unless it is full and not being drained
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      break_det <= brk_s;
      if (done_s && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (done_s) begin
        rx_data    <= shift_r;
        parity_err <= par_err_r;
        frame_err  <= ~rx_sync_r;
        rx_valid   <= 1'b1;
        if (hs_s) begin
          overrun <= 1'b0;
        end
      end else if (hs_s) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances (8N1, 8E1, 7N1, 9N1) at 16 clocks per bit,
// each with its own rx line and ready input; a negedge monitor records pulses and handshakes.
module tb_uart_rx_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [3:0] rx_v, ready_v;
  logic [3:0] valid_w, perr_w, ferr_w, ovr_w, brk_w;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] d3;
  logic [8:0] data_a [4];

  int n_checks = 0;
  int n_fail   = 0;

  int       vcnt    [4] = '{0, 0, 0, 0};
  int       hs_cnt  [4] = '{0, 0, 0, 0};
  int       bcnt    [4] = '{0, 0, 0, 0};
  logic [8:0] last_data [4];
  logic       last_perr [4];
  logic       last_ferr [4];

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0)) u_8n (
    .clock(clock), .reset(reset), .rx(rx_v[0]), .rx_data(d0), .rx_valid(valid_w[0]),
    .rx_ready(ready_v[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0]),
    .overrun(ovr_w[0]), .break_det(brk_w[0]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1)) u_8e (
    .clock(clock), .reset(reset), .rx(rx_v[1]), .rx_data(d1), .rx_valid(valid_w[1]),
    .rx_ready(ready_v[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1]),
    .overrun(ovr_w[1]), .break_det(brk_w[1]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(0)) u_7n (
    .clock(clock), .reset(reset), .rx(rx_v[2]), .rx_data(d2), .rx_valid(valid_w[2]),
    .rx_ready(ready_v[2]), .parity_err(perr_w[2]), .frame_err(ferr_w[2]),
    .overrun(ovr_w[2]), .break_det(brk_w[2]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(9), .PARITY(0)) u_9n (
    .clock(clock), .reset(reset), .rx(rx_v[3]), .rx_data(d3), .rx_valid(valid_w[3]),
    .rx_ready(ready_v[3]), .parity_err(perr_w[3]), .frame_err(ferr_w[3]),
    .overrun(ovr_w[3]), .break_det(brk_w[3]));

  always_comb begin
    data_a[0] = {1'b0, d0};
    data_a[1] = {1'b0, d1};
    data_a[2] = {2'b00, d2};
    data_a[3] = d3;
  end

  // Record valid cycles, handshakes (with the word taken) and break pulses per instance
  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (valid_w[k]) vcnt[k] <= vcnt[k] + 1;
      if (brk_w[k]) bcnt[k] <= bcnt[k] + 1;
      if (valid_w[k] && ready_v[k]) begin
        hs_cnt[k]    <= hs_cnt[k] + 1;
        last_data[k] <= data_a[k];
        last_perr[k] <= perr_w[k];
        last_ferr[k] <= ferr_w[k];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int d, input logic [8:0] val, input int nb,
                      input bit has_par, input logic par, input logic stop);
    rx_v[d] = 1'b0;
    tick(16);
    for (int i = 0; i < nb; i++) begin
      rx_v[d] = val[i];
      tick(16);
    end
    if (has_par) begin
      rx_v[d] = par;
      tick(16);
    end
    rx_v[d] = stop;
    tick(16);
    rx_v[d] = 1'b1;
    tick(4);
  endtask

  task automatic scen_single(input int d, input logic [8:0] val, input int nb);
    int v0, h0;
    v0 = vcnt[d];
    h0 = hs_cnt[d];
    send(d, val, nb, 1'b0, 1'b0, 1'b1);
    check_eq($sformatf("s1_valid_cycles_%0d", d), 32'(vcnt[d] - v0), 32'd1);
    check_eq($sformatf("s1_handshakes_%0d", d), 32'(hs_cnt[d] - h0), 32'd1);
    check_eq($sformatf("s1_data_%0d", d), 32'(last_data[d]), 32'(val));
    check_eq($sformatf("s1_perr_%0d", d), 32'(last_perr[d]), 32'd0);
    check_eq($sformatf("s1_ferr_%0d", d), 32'(last_ferr[d]), 32'd0);
  endtask

  task automatic scen_overrun(input int d, input logic [8:0] a, input logic [8:0] b, input int nb);
    ready_v[d] = 1'b0;
    send(d, a, nb, 1'b0, 1'b0, 1'b1);
    check_eq($sformatf("s4_valid_first_%0d", d), 32'(valid_w[d]), 32'd1);
    check_eq($sformatf("s4_data_first_%0d", d), 32'(data_a[d]), 32'(a));
    check_eq($sformatf("s4_ovr_first_%0d", d), 32'(ovr_w[d]), 32'd0);
    send(d, b, nb, 1'b0, 1'b0, 1'b1);
    check_eq($sformatf("s4_data_kept_%0d", d), 32'(data_a[d]), 32'(a));
    check_eq($sformatf("s4_ovr_set_%0d", d), 32'(ovr_w[d]), 32'd1);
    check_eq($sformatf("s4_valid_held_%0d", d), 32'(valid_w[d]), 32'd1);
    ready_v[d] = 1'b1;
    tick(1);
    ready_v[d] = 1'b0;
    tick(1);
    check_eq($sformatf("s4_valid_clr_%0d", d), 32'(valid_w[d]), 32'd0);
    check_eq($sformatf("s4_ovr_clr_%0d", d), 32'(ovr_w[d]), 32'd0);
    check_eq($sformatf("s4_hs_data_%0d", d), 32'(last_data[d]), 32'(a));
    ready_v[d] = 1'b1;
    tick(4);
  endtask

  initial begin
    int v0, b0;
    reset   = 1'b1;
    rx_v    = 4'hF;
    ready_v = 4'h0;
    tick(3);
    check_eq("rst_valid", 32'(valid_w), 32'd0);
    check_eq("rst_perr", 32'(perr_w), 32'd0);
    check_eq("rst_ferr", 32'(ferr_w), 32'd0);
    check_eq("rst_ovr", 32'(ovr_w), 32'd0);
    check_eq("rst_brk", 32'(brk_w), 32'd0);
    for (int k = 0; k < 4; k++) check_eq($sformatf("rst_data_%0d", k), 32'(data_a[k]), 32'd0);
    reset = 1'b0;
    tick(4);
    ready_v = 4'hF;

    scen_single(0, 9'h055, 8);
    scen_single(2, 9'h055, 7);
    scen_single(3, 9'h1A5, 9);

    // 0x62 has three ones: even parity bit must be 1
    send(1, 9'h062, 8, 1'b1, 1'b0, 1'b1);
    check_eq("s2_data_badpar", 32'(last_data[1]), 32'h62);
    check_eq("s2_perr_badpar", 32'(last_perr[1]), 32'd1);
    check_eq("s2_ferr_badpar", 32'(last_ferr[1]), 32'd0);
    send(1, 9'h062, 8, 1'b1, 1'b1, 1'b1);
    check_eq("s2_data_goodpar", 32'(last_data[1]), 32'h62);
    check_eq("s2_perr_goodpar", 32'(last_perr[1]), 32'd0);

    v0 = vcnt[0];
    rx_v[0] = 1'b0;
    tick(5);
    rx_v[0] = 1'b1;
    tick(40);
    check_eq("s3_no_word", 32'(vcnt[0] - v0), 32'd0);
    check_eq("s3_valid_low", 32'(valid_w[0]), 32'd0);
    send(0, 9'h063, 8, 1'b0, 1'b0, 1'b1);
    check_eq("s3_data_after", 32'(last_data[0]), 32'h63);

    send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
    check_eq("fe_data", 32'(last_data[0]), 32'h3C);
    check_eq("fe_ferr", 32'(last_ferr[0]), 32'd1);
    tick(20);

    v0 = vcnt[0];
    b0 = bcnt[0];
    rx_v[0] = 1'b0;
    tick(192);
    rx_v[0] = 1'b1;
    tick(8);
    check_eq("s5_break_pulses", 32'(bcnt[0] - b0), 32'd1);
    check_eq("s5_no_word", 32'(vcnt[0] - v0), 32'd0);
    send(0, 9'h063, 8, 1'b0, 1'b0, 1'b1);
    check_eq("s5_data_after", 32'(last_data[0]), 32'h63);
    check_eq("s5_ferr_after", 32'(last_ferr[0]), 32'd0);

    scen_overrun(0, 9'h055, 9'h062, 8);
    scen_overrun(2, 9'h055, 9'h062, 7);
    scen_overrun(3, 9'h1A5, 9'h062, 9);

    // Reset in the middle of data bit 3 of 0xA5 (bits LSB first: 1,0,1,0)
    rx_v[0] = 1'b0;
    tick(16);
    rx_v[0] = 1'b1; tick(16);
    rx_v[0] = 1'b0; tick(16);
    rx_v[0] = 1'b1; tick(16);
    rx_v[0] = 1'b0; tick(8);
    reset = 1'b1;
    #2;
    check_eq("s6_valid", 32'(valid_w[0]), 32'd0);
    check_eq("s6_data", 32'(data_a[0]), 32'd0);
    check_eq("s6_perr", 32'(perr_w[0]), 32'd0);
    check_eq("s6_ferr", 32'(ferr_w[0]), 32'd0);
    check_eq("s6_ovr", 32'(ovr_w[0]), 32'd0);
    check_eq("s6_brk", 32'(brk_w[0]), 32'd0);
    rx_v[0] = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);
    scen_single(0, 9'h055, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
